seven_segment_reader: RTL
=========================

// Module: seven_segment_reader
// PURPOSE
//   Receive end of the seven-segment digit link: deserialises 7-bit segment patterns shifted
//   in over a 3-wire serial link, decodes them back to a BCD digit 0-9, and flags malformed
//   frames and digits that do not follow the expected up-count step. Sits on the io_in/io_out
//   tile pins, so a seven-segment counter on another tile can be checked frame by frame.
// PARAMETERS
//   STEP       1  expected digit increment between consecutive good frames, mod 10 (1..9)
//   CHECK_SEQ  1  1 = sequence checking enabled; 0 = seq_err held at 0
// PORTS
//   io_in[0]   clk       in   1  system clock; all logic on rising edge
//   io_in[1]   reset     in   1  synchronous, active-high reset
//   io_in[2]   ser_data  in   1  segment bit; async, sampled on ser_clk rise
//   io_in[3]   ser_clk   in   1  serial bit clock; async, must be slower than clk/4
//   io_in[4]   frame     in   1  high for the duration of one 7-bit frame
//   io_in[7:5] -         in   3  unused, ignored
//   io_out[3:0] digit    out  4  last good decoded digit, BCD 0-9
//   io_out[4]  valid     out  1  one-clk pulse per good frame
//   io_out[5]  frame_err out 1  sticky: last frame malformed; cleared by next good frame
//   io_out[6]  seq_err   out  1  sticky: last good digit != previous good digit + STEP
//   io_out[7]  -         out  1  tied 0
// BEHAVIOUR
//   Reset: digit=0, valid=0, frame_err=0, seq_err=0, shift reg=0, bit count=0, state IDLE,
//     have_prev=0, sync flops=0. Reset asserted mid-frame discards the partial frame.
//   Input sync: ser_data, ser_clk, frame each pass 2 flops, then a 3rd flop for edge detect.
//     Edges are detected on the synchronised copies only.
//   FSM: IDLE -> SHIFT on frame rising edge (bit count cleared, shift reg cleared).
//     SHIFT: each ser_clk rising edge shifts synced ser_data in at LSB (first bit = seg g,
//     last = seg a; final reg = {g,f,e,d,c,b,a}), bit count saturates at 8.
//     SHIFT -> IDLE on frame falling edge; frame is evaluated in that same cycle.
//     ser_clk edges in IDLE ignored. ser_clk edge coinciding with frame fall is ignored.
//   Evaluation (registered, outputs update on the next clk edge):
//     good = bit count == 7 AND pattern in table; else frame_err<=1, digit unchanged, no valid.
//     Table (active-high, a=bit0): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//     Any other pattern (incl. 00, 7F-with-extra bits) -> frame_err.
//     On good: digit<=decoded, valid<=1 for exactly one clk, frame_err<=0;
//       if CHECK_SEQ and have_prev: seq_err <= (decoded != (prev+STEP) mod 10); have_prev<=1.
//       First good frame after reset never sets seq_err. seq_err only changes on good frames.
//   Latency: frame pin sampled low at clk edge N -> valid/digit visible after edge N+3.
//   Wrap-around: mod-10 add computed in 5 bits then reduced (9+1->0, 9+2->1, 8+STEP 9->7).
//   Back-to-back frames need >=1 synced clk of frame low between them; shorter gaps merge.
// TESTING
//   1. Reset, send frame 3F (7 bits) -> digit=0, valid 1 clk, frame_err=0, seq_err=0.
//   2. Frames 06,5B,4F (STEP=1) -> digits 1,2,3, three valid pulses, seq_err stays 0.
//   3. Frame 6F then 3F then 5B -> 9,0 ok; 0->2 sets seq_err=1; next 4F (3) clears it.
//   4. Frame of 6 bits, then 8 bits, then pattern 01 -> no valid, frame_err=1, digit held;
//      following 66 -> digit=4, frame_err=0.
//   5. Assert reset after 4 ser_clk edges of a frame -> all outputs 0; next full 07 -> digit 7,
//      no seq_err (have_prev cleared).
//   6. STEP=2 build: 0,2,4,6,8,0 -> seq_err 0 throughout; 0,1 -> seq_err 1.

Source files
------------

// File: rtl/seven_segment_reader.sv
// rtl/seven_segment_reader.sv - seven-segment serial link receiver with frame and sequence checking
//
// Deserialises 7-bit segment patterns shifted in over a 3-wire link (ser_data,
// ser_clk, frame), decodes them back to a BCD digit and flags malformed frames
// and digits that break the expected up-count step.
//
// Ports (tile pins):
//   io_in[0]    clk        system clock, rising edge
//   io_in[1]    reset      synchronous, active-high
//   io_in[2]    ser_data   segment bit, async
//   io_in[3]    ser_clk    serial bit clock, async, slower than clk/4
//   io_in[4]    frame      high for the duration of one frame
//   io_in[7:5]  unused
//   io_out[3:0] digit      last good decoded digit
//   io_out[4]   valid      one-clk pulse per good frame
//   io_out[5]   frame_err  sticky, cleared by the next good frame
//   io_out[6]   seq_err    sticky, updated on good frames only
//   io_out[7]   tied 0

module seven_segment_reader #(
  parameter int STEP      = 1,
  parameter int CHECK_SEQ = 1
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic clk;
  logic reset;
  assign clk   = io_in[0];
  assign reset = io_in[1];

  // Data only needs two flops; clock and frame get a third for edge detection.
  logic [1:0] data_sync;
  logic [2:0] sclk_sync;
  logic [2:0] frame_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_sync  <= '0;
      sclk_sync  <= '0;
      frame_sync <= '0;
    end else begin
      data_sync  <= {data_sync[0], io_in[2]};
      sclk_sync  <= {sclk_sync[1:0], io_in[3]};
      frame_sync <= {frame_sync[1:0], io_in[4]};
    end
  end

  logic sclk_rise, frame_rise, frame_fall;
  assign sclk_rise  =  sclk_sync[1]  & ~sclk_sync[2];
  assign frame_rise =  frame_sync[1] & ~frame_sync[2];
  assign frame_fall = ~frame_sync[1] &  frame_sync[2];

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (frame_rise) state_nxt = SHIFT;
      SHIFT: if (frame_fall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic clear_en, shift_en, eval_en;
  always_comb begin
    clear_en = 1'b0;
    shift_en = 1'b0;
    eval_en  = 1'b0;
    case (state)
      IDLE:  clear_en = frame_rise;
      // A bit clock edge landing on the frame's closing edge is not part of the frame.
      SHIFT: begin
        shift_en = sclk_rise & ~frame_fall;
        eval_en  = frame_fall;
      end
      default: ;
    endcase
  end

  logic [6:0] shift_reg;
  logic [3:0] bit_cnt;
  // Snapshot of the closed frame so a quickly following frame cannot disturb it.
  logic       eval_pend;
  logic [6:0] eval_pat;
  logic       eval_len_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      eval_pend   <= 1'b0;
      eval_pat    <= '0;
      eval_len_ok <= 1'b0;
    end else begin
      eval_pend <= eval_en;
      if (eval_en) begin
        eval_pat    <= shift_reg;
        eval_len_ok <= (bit_cnt == 4'd7);
      end
      if (clear_en) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (shift_en) begin
        shift_reg <= {shift_reg[5:0], data_sync[1]};
        if (bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  logic       dec_ok;
  logic [3:0] dec_digit;
  always_comb begin
    dec_ok    = 1'b1;
    dec_digit = 4'd0;
    case (eval_pat)
      7'h3F: dec_digit = 4'd0;
      7'h06: dec_digit = 4'd1;
      7'h5B: dec_digit = 4'd2;
      7'h4F: dec_digit = 4'd3;
      7'h66: dec_digit = 4'd4;
      7'h6D: dec_digit = 4'd5;
      7'h7D: dec_digit = 4'd6;
      7'h07: dec_digit = 4'd7;
      7'h7F: dec_digit = 4'd8;
      7'h6F: dec_digit = 4'd9;
      default: dec_ok = 1'b0;
    endcase
  end

  logic [3:0] digit;
  logic       valid, frame_err, seq_err, have_prev;

  // Next expected digit: add in 5 bits so 9+9 cannot overflow, then fold mod 10.
  logic [4:0] step_sum;
  logic [3:0] exp_digit;
  always_comb begin
    step_sum  = {1'b0, digit} + 5'(STEP);
    exp_digit = (step_sum >= 5'd10) ? 4'(step_sum - 5'd10) : step_sum[3:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      seq_err   <= 1'b0;
      have_prev <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (eval_pend) begin
        if (eval_len_ok && dec_ok) begin
          digit     <= dec_digit;
          valid     <= 1'b1;
          frame_err <= 1'b0;
          have_prev <= 1'b1;
          if (CHECK_SEQ != 0 && have_prev) seq_err <= (dec_digit != exp_digit);
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

  assign io_out = {1'b0, seq_err, frame_err, valid, digit};

  logic unused_ok;
  assign unused_ok = ^io_in[7:5];

endmodule
